hazard_ctrl: RTL and testbench

Pipeline hazard and stall controller for the 5-stage RISC-V core. It drives the stall/flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, including the ID/EX `Flush_E` input. It generates the EX-stage forwarding selects. It sequences multi-cycle data-memory accesses through a small wait FSM with a timeout.

---
 rtl/hazard_ctrl.sv | 158 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller: forwarding selects, load-use and branch bubbles, memory-wait FSM with timeout.
// Optional saturating stall/flush performance counters are enabled by HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
    parameter int REG_ADDR_WIDTH  = 5,
    parameter int RESULTSRC_WIDTH = 2,
    parameter int MEM_TIMEOUT     = 16,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [REG_ADDR_WIDTH-1:0]  rs1_D,
    input  logic [REG_ADDR_WIDTH-1:0]  rs2_D,
    input  logic [REG_ADDR_WIDTH-1:0]  rs1_E,
    input  logic [REG_ADDR_WIDTH-1:0]  rs2_E,
    input  logic [REG_ADDR_WIDTH-1:0]  rd_E,
    input  logic [RESULTSRC_WIDTH-1:0] ResultSrc_E,
    input  logic                       PCSrc_E,
    input  logic [REG_ADDR_WIDTH-1:0]  rd_M,
    input  logic [REG_ADDR_WIDTH-1:0]  rd_W,
    input  logic                       RegWrite_M,
    input  logic                       RegWrite_W,
    input  logic                       MemAccess_M,
    input  logic                       MemReady_M,
    output logic                       Stall_F,
    output logic                       Stall_D,
    output logic                       Stall_E,
    output logic                       Stall_M,
    output logic                       Flush_D,
    output logic                       Flush_E,
    output logic                       Flush_W,
    output logic [1:0]                 ForwardA_E,
    output logic [1:0]                 ForwardB_E,
    output logic                       MemErr,
    output logic [CNT_WIDTH-1:0]       StallCnt,
    output logic [CNT_WIDTH-1:0]       FlushCnt
);

    typedef enum logic [1:0] {RUN, WAIT, ERR} state_t;

    localparam int WCW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCW-1:0] TIMEOUT = WCW'(MEM_TIMEOUT);
    localparam logic [RESULTSRC_WIDTH-1:0] SRC_LOAD = RESULTSRC_WIDTH'(1);

    state_t         state_q;
    logic [WCW-1:0] wait_cnt_q;
    logic           mem_err_q;
    logic           lw;
    logic           ms;

    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_WIDTH-1:0] rs,
                                           input logic [REG_ADDR_WIDTH-1:0] rdm,
                                           input logic [REG_ADDR_WIDTH-1:0] rdw,
                                           input logic rwm,
                                           input logic rww);
        if (rwm && rdm != '0 && rdm == rs)
            return 2'b10;
        else if (rww && rdw != '0 && rdw == rs)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign lw = (ResultSrc_E == SRC_LOAD) && (rd_E != '0) && ((rd_E == rs1_D) || (rd_E == rs2_D));
    assign ms = MemAccess_M && !MemReady_M;

    always_comb begin
        Stall_F    = 1'b0;
        Stall_D    = 1'b0;
        Stall_E    = 1'b0;
        Stall_M    = 1'b0;
        Flush_D    = 1'b0;
        Flush_E    = 1'b0;
        Flush_W    = 1'b0;
        ForwardA_E = 2'b00;
        ForwardB_E = 2'b00;
        if (!rst) begin
            ForwardA_E = fwd_sel(rs1_E, rd_M, rd_W, RegWrite_M, RegWrite_W);
            ForwardB_E = fwd_sel(rs2_E, rd_M, rd_W, RegWrite_M, RegWrite_W);
            // A memory stall freezes everything up to MEM, so a taken branch waits in EX.
            if (state_q == ERR || ms) begin
                Stall_F = 1'b1;
                Stall_D = 1'b1;
                Stall_E = 1'b1;
                Stall_M = 1'b1;
                Flush_W = 1'b1;
            end else begin
                Stall_F = lw;
                Stall_D = lw;
                Flush_D = PCSrc_E;
                Flush_E = lw | PCSrc_E;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (ms) begin
                        state_q    <= WAIT;
                        wait_cnt_q <= WCW'(1);
                    end
                end
                WAIT: begin
                    // Completion and abandonment both end the wait without error.
                    if (!ms) begin
                        state_q    <= RUN;
                        wait_cnt_q <= '0;
                    end else if (wait_cnt_q == TIMEOUT) begin
                        state_q   <= ERR;
                        mem_err_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                ERR:     mem_err_q <= 1'b1;
                default: state_q   <= RUN;
            endcase
        end
    end

    assign MemErr = mem_err_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (Stall_F && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + 1'b1;
        if (Flush_D && !(&flush_cnt_q))
            flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;
`else
    assign StallCnt = '0;
    assign FlushCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: vector table, hand-written wait/timeout/reset sequences, randomized run vs. model.
module tb_hazard_ctrl;
    localparam int RW  = 5;
    localparam int TMO = 4;
    localparam int CW  = 4;
    localparam int CNT_MAX = (1 << CW) - 1;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [RW-1:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
    logic [1:0]    ResultSrc_E;
    logic          PCSrc_E, RegWrite_M, RegWrite_W, MemAccess_M, MemReady_M;
    logic          Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W, MemErr;
    logic [1:0]    ForwardA_E, ForwardB_E;
    logic [CW-1:0] StallCnt, FlushCnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_ADDR_WIDTH(RW), .RESULTSRC_WIDTH(2), .MEM_TIMEOUT(TMO), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
        .ResultSrc_E(ResultSrc_E), .PCSrc_E(PCSrc_E), .rd_M(rd_M), .rd_W(rd_W),
        .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
        .MemAccess_M(MemAccess_M), .MemReady_M(MemReady_M),
        .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E), .Stall_M(Stall_M),
        .Flush_D(Flush_D), .Flush_E(Flush_E), .Flush_W(Flush_W),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
        .MemErr(MemErr), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    int total = 0;
    int bad   = 0;

    // Model state: consecutive unanswered memory cycles, sticky error, counter values.
    int m_run = 0;
    bit m_err = 1'b0;
    int m_sc  = 0;
    int m_fc  = 0;
    logic e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fw;
    logic [1:0] e_fa, e_fb;

    typedef struct {
        logic [RW-1:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
        logic [1:0]    rsrc;
        logic          pcsrc, rwm, rww;
        logic          sf, fd, fe;
        logic [1:0]    fa, fb;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwd(input logic [RW-1:0] rs);
        if (RegWrite_M && rd_M != 0 && rd_M == rs) return 2'b10;
        if (RegWrite_W && rd_W != 0 && rd_W == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic expect_now();
        bit lw, ms;
        {e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fw} = '0;
        e_fa = 2'b00;
        e_fb = 2'b00;
        if (!rst) begin
            e_fa = fwd(rs1_E);
            e_fb = fwd(rs2_E);
            lw = (ResultSrc_E == 2'b01) && rd_E != 0 && (rd_E == rs1_D || rd_E == rs2_D);
            ms = MemAccess_M && !MemReady_M;
            if (m_err || ms) begin
                {e_sf, e_sd, e_se, e_sm, e_fw} = '1;
            end else begin
                e_sf = lw;
                e_sd = lw;
                e_fd = PCSrc_E;
                e_fe = lw | PCSrc_E;
            end
        end
    endtask

    task automatic check_all();
        #1;
        if (rst) begin
            m_run = 0; m_err = 1'b0; m_sc = 0; m_fc = 0;
        end
        expect_now();
        chk("stall_f", Stall_F, e_sf);
        chk("stall_d", Stall_D, e_sd);
        chk("stall_e", Stall_E, e_se);
        chk("stall_m", Stall_M, e_sm);
        chk("flush_d", Flush_D, e_fd);
        chk("flush_e", Flush_E, e_fe);
        chk("flush_w", Flush_W, e_fw);
        chk("fwd_a", ForwardA_E, e_fa);
        chk("fwd_b", ForwardB_E, e_fb);
        chk("mem_err", MemErr, m_err);
        chk("stall_cnt", StallCnt, PERF ? 32'(m_sc) : 32'd0);
        chk("flush_cnt", FlushCnt, PERF ? 32'(m_fc) : 32'd0);
    endtask

    task automatic advance();
        @(posedge clk);
        if (!rst) begin
            if (!m_err) begin
                if (MemAccess_M && !MemReady_M) begin
                    m_run++;
                    if (m_run > TMO) m_err = 1'b1;
                end else begin
                    m_run = 0;
                end
            end
            if (e_sf && m_sc < CNT_MAX) m_sc++;
            if (e_fd && m_fc < CNT_MAX) m_fc++;
        end
        #1;
    endtask

    task automatic tick();
        check_all();
        advance();
    endtask

    task automatic neutral();
        {rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W} = '0;
        ResultSrc_E = 2'b00;
        {PCSrc_E, RegWrite_M, RegWrite_W, MemAccess_M, MemReady_M} = '0;
    endtask

    vec_t vecs[10];
    int   burst;

    initial begin
        //         rs1D rs2D rs1E rs2E rdE rdM rdW rsrc pc rwm rww  sf fd fe  fa     fb
        vecs[0] = '{5, 0, 0, 0, 5, 0, 0, 2'b01, 0, 0, 0,  1, 0, 1, 2'b00, 2'b00};
        vecs[1] = '{0, 0, 5, 0, 0, 0, 5, 2'b00, 0, 0, 1,  0, 0, 0, 2'b01, 2'b00};
        vecs[2] = '{0, 0, 0, 7, 0, 7, 7, 2'b00, 0, 1, 1,  0, 0, 0, 2'b00, 2'b10};
        vecs[3] = '{0, 0, 0, 0, 0, 7, 7, 2'b00, 0, 1, 1,  0, 0, 0, 2'b00, 2'b00};
        vecs[4] = '{0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0,  0, 1, 1, 2'b00, 2'b00};
        vecs[5] = '{1, 3, 0, 0, 3, 0, 0, 2'b01, 1, 0, 0,  1, 1, 1, 2'b00, 2'b00};
        vecs[6] = '{0, 2, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00};
        vecs[7] = '{4, 0, 0, 0, 4, 0, 0, 2'b10, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00};
        vecs[8] = '{0, 0, 9, 9, 0, 9, 9, 2'b00, 0, 0, 1,  0, 0, 0, 2'b01, 2'b01};
        vecs[9] = '{0, 0, 0, 3, 0, 0, 3, 2'b00, 0, 1, 1,  0, 0, 0, 2'b00, 2'b01};

        neutral();
        rst = 1'b1;
        PCSrc_E = 1'b1; MemAccess_M = 1'b1;
        rd_M = 3; rs1_E = 3; RegWrite_M = 1'b1;
        #1;
        check_all();
        chk("rst_stall_f", Stall_F, 1'b0);
        chk("rst_fwd_a", ForwardA_E, 2'b00);
        @(posedge clk); #1;
        neutral();
        rst = 1'b0;

        foreach (vecs[i]) begin
            rs1_D = vecs[i].rs1_D; rs2_D = vecs[i].rs2_D;
            rs1_E = vecs[i].rs1_E; rs2_E = vecs[i].rs2_E;
            rd_E = vecs[i].rd_E; rd_M = vecs[i].rd_M; rd_W = vecs[i].rd_W;
            ResultSrc_E = vecs[i].rsrc; PCSrc_E = vecs[i].pcsrc;
            RegWrite_M = vecs[i].rwm; RegWrite_W = vecs[i].rww;
            MemAccess_M = 1'b0; MemReady_M = 1'b0;
            check_all();
            chk($sformatf("vec%0d_stall_f", i), Stall_F, vecs[i].sf);
            chk($sformatf("vec%0d_stall_d", i), Stall_D, vecs[i].sf);
            chk($sformatf("vec%0d_flush_d", i), Flush_D, vecs[i].fd);
            chk($sformatf("vec%0d_flush_e", i), Flush_E, vecs[i].fe);
            chk($sformatf("vec%0d_fwd_a", i), ForwardA_E, vecs[i].fa);
            chk($sformatf("vec%0d_fwd_b", i), ForwardB_E, vecs[i].fb);
            advance();
        end

        // Multi-cycle access with a taken branch held across the wait.
        neutral();
        PCSrc_E = 1'b1; MemAccess_M = 1'b1;
        for (int c = 0; c < 4; c++) begin
            MemReady_M = (c == 3);
            check_all();
            chk($sformatf("memwait_c%0d_stall_f", c), Stall_F, c < 3);
            chk($sformatf("memwait_c%0d_stall_m", c), Stall_M, c < 3);
            chk($sformatf("memwait_c%0d_flush_w", c), Flush_W, c < 3);
            chk($sformatf("memwait_c%0d_flush_d", c), Flush_D, c == 3);
            advance();
        end

        // Single-cycle access: no stall at all.
        neutral();
        MemAccess_M = 1'b1; MemReady_M = 1'b1;
        check_all();
        chk("single_access_stall_m", Stall_M, 1'b0);
        advance();

        // Timeout into the error state, then reset out of it.
        neutral();
        MemAccess_M = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check_all();
            chk($sformatf("tmo_c%0d_mem_err", c), MemErr, 1'b0);
            advance();
        end
        MemAccess_M = 1'b0;
        for (int c = 0; c < 2; c++) begin
            check_all();
            chk($sformatf("err_c%0d_mem_err", c), MemErr, 1'b1);
            chk($sformatf("err_c%0d_stall_m", c), Stall_M, 1'b1);
            advance();
        end
        rst = 1'b1;
        PCSrc_E = 1'b1;
        check_all();
        chk("err_rst_mem_err", MemErr, 1'b0);
        chk("err_rst_stall_f", Stall_F, 1'b0);
        chk("err_rst_flush_d", Flush_D, 1'b0);
        #1 rst = 1'b0;
        neutral();
        check_all();
        chk("after_err_rst_stall_f", Stall_F, 1'b0);
        advance();

        // Reset in the middle of a wait; the next access must start a fresh timeout.
        MemAccess_M = 1'b1;
        tick();
        tick();
        #2 rst = 1'b1;
        check_all();
        chk("wait_rst_stall_e", Stall_E, 1'b0);
        #1 rst = 1'b0;
        MemAccess_M = 1'b0;
        check_all();
        chk("after_wait_rst_stall_f", Stall_F, 1'b0);
        advance();
        MemAccess_M = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check_all();
            chk($sformatf("fresh_tmo_c%0d_mem_err", c), MemErr, 1'b0);
            advance();
        end
        MemAccess_M = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Randomized run against the model, with memory bursts and occasional resets.
        burst = 0;
        for (int n = 0; n < 600; n++) begin
            rs1_D = RW'($urandom_range(0, 3)); rs2_D = RW'($urandom_range(0, 3));
            rs1_E = RW'($urandom_range(0, 3)); rs2_E = RW'($urandom_range(0, 3));
            rd_E  = RW'($urandom_range(0, 3)); rd_M  = RW'($urandom_range(0, 3));
            rd_W  = RW'($urandom_range(0, 3));
            ResultSrc_E = 2'($urandom_range(0, 3));
            PCSrc_E    = ($urandom_range(0, 3) == 0);
            RegWrite_M = $urandom_range(0, 1) == 1;
            RegWrite_W = $urandom_range(0, 1) == 1;
            if (burst == 0 && $urandom_range(0, 3) == 0) burst = $urandom_range(1, 7);
            if (burst > 0) begin
                MemAccess_M = 1'b1;
                MemReady_M  = (burst == 1) && ($urandom_range(0, 1) == 1);
                burst--;
            end else begin
                MemAccess_M = $urandom_range(0, 3) == 0;
                MemReady_M  = 1'b1;
            end
            rst = ($urandom_range(0, 39) == 0);
            tick();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
